// File: rtl/text_banner_ctrl_if.sv
// Purpose: bundles the scan, request, ROM and overlay signals between the game/VGA side and the banner sequencer.
// Latency: none, this file holds wiring only.
// Backpressure: none; every signal is sampled or driven on each pixel clock.
interface text_banner_ctrl_if;
  logic [9:0]  iVGA_X;
  logic [9:0]  iVGA_Y;
  logic        iFRAME_START;
  logic [3:0]  iREQ;
  logic        iCLR;
  logic        iROM_Q;
  logic [14:0] oROM_ADDR;
  logic [2:0]  oRGB;
  logic        oBUSY;
  logic [1:0]  oBANNER_ID;

  // sequencer side
  modport slave (
    input  iVGA_X, iVGA_Y, iFRAME_START, iREQ, iCLR, iROM_Q,
    output oROM_ADDR, oRGB, oBUSY, oBANNER_ID
  );

  // game logic / VGA side
  modport master (
    output iVGA_X, iVGA_Y, iFRAME_START, iREQ, iCLR, iROM_Q,
    input  oROM_ADDR, oRGB, oBUSY, oBANNER_ID
  );
endinterface

// File: rtl/text_banner_ctrl.sv
// Purpose: arbitrates banner requests, times banners in frames with blinking, and drives the shared banner ROM address and overlay colour.
// Latency: oROM_ADDR 1 clock after X/Y, oRGB 3 clocks after X/Y; state changes land only on frame-start cycles. iCLR is the exception and takes effect at once.
// Backpressure: none; one-cycle request pulses latch into a pending register. Optional preemption is enabled by TEXT_BANNER_PREEMPT_EN.
module text_banner_ctrl #(
  parameter int          BANNER_X     = 350,
  parameter int          BANNER_Y     = 300,
  parameter int          BANNER_W     = 120,
  parameter int          BANNER_H     = 48,
  parameter int          SHOW_FRAMES  = 180,
  parameter int          BLINK_PERIOD = 16,
  parameter logic [2:0]  FG_RGB       = 3'b001
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  text_banner_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  localparam logic [9:0]  BX_FIRST = 10'(BANNER_X);
  localparam logic [9:0]  BX_LAST  = 10'(BANNER_X + BANNER_W - 1);
  localparam logic [9:0]  BY_FIRST = 10'(BANNER_Y);
  localparam logic [9:0]  BY_LAST  = 10'(BANNER_Y + BANNER_H - 1);
  localparam logic [14:0] ROW_W    = 15'(BANNER_W);
  localparam logic [14:0] BANK_SZ  = 15'(BANNER_W * BANNER_H);
  localparam logic [7:0]  SF_LAST  = 8'(SHOW_FRAMES - 1);
  localparam logic [7:0]  BP_LAST  = 8'(BLINK_PERIOD - 1);

  state_t      state_q;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  id_q;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  blink_cnt_q;
  logic        vis_q;
  logic        busy_q;
  logic [14:0] addr_q, addr_d;
  logic        win1_q, win2_q;
  logic [2:0]  rgb_q;

  logic [3:0]  sel;
  logic        top_vld;
  logic [1:0]  top_id;
  logic        pick;
  logic [1:0]  pick_id;
  logic        in_win;
  logic [9:0]  dx, dy;

  // Priority pick over pending plus same-cycle requests; decides whether this frame start takes a banner
  always_comb begin
    sel     = pend_q | bus.iREQ;
    top_vld = |sel;
    top_id  = 2'd0;
    if (sel[3])      top_id = 2'd3;
    else if (sel[2]) top_id = 2'd2;
    else if (sel[1]) top_id = 2'd1;
    pick    = 1'b0;
    pick_id = top_id;
    if (bus.iFRAME_START) begin
      unique case (state_q)
        ST_IDLE, ST_GAP: pick = top_vld;
        ST_SHOW: begin
`ifdef TEXT_BANNER_PREEMPT_EN
          if (top_vld && (top_id > id_q)) begin
            pick = 1'b1;
          end else
`endif
          if (sel[id_q]) begin
            // re-request of the shown banner restarts it
            pick    = 1'b1;
            pick_id = id_q;
          end
        end
        default: ;
      endcase
    end
    pend_d = sel & ~(pick ? (4'b0001 << pick_id) : 4'b0000);
  end

  // Window test and ROM address for the current scan position
  always_comb begin
    in_win = (bus.iVGA_X >= BX_FIRST) && (bus.iVGA_X <= BX_LAST) &&
             (bus.iVGA_Y >= BY_FIRST) && (bus.iVGA_Y <= BY_LAST);
    dx     = bus.iVGA_X - BX_FIRST;
    dy     = bus.iVGA_Y - BY_FIRST;
    addr_d = 15'd0;
    if (in_win) begin
      addr_d = (BANK_SZ * {13'd0, id_q}) + ({5'd0, dy} * ROW_W) + {5'd0, dx};
    end
  end

  // Banner sequencer: moves only on frame start so a banner never tears mid-frame; iCLR overrides
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 4'd0;
      id_q        <= 2'd0;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      vis_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else if (bus.iCLR) begin
      state_q     <= ST_IDLE;
      pend_q      <= 4'd0;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      vis_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (pick) begin
        state_q     <= ST_SHOW;
        id_q        <= pick_id;
        frame_cnt_q <= 8'd0;
        blink_cnt_q <= 8'd0;
        vis_q       <= 1'b1;
        busy_q      <= 1'b1;
      end else if (bus.iFRAME_START) begin
        unique case (state_q)
          ST_SHOW: begin
            if (frame_cnt_q == SF_LAST) begin
              state_q <= ST_GAP;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              if (BLINK_PERIOD > 0) begin
                if (blink_cnt_q == BP_LAST) begin
                  blink_cnt_q <= 8'd0;
                  vis_q       <= ~vis_q;
                end else begin
                  blink_cnt_q <= blink_cnt_q + 8'd1;
                end
              end
            end
          end
          ST_GAP: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Pixel pipeline: address and window flag, then window delayed to meet ROM data, then colour
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_q <= 15'd0;
      win1_q <= 1'b0;
      win2_q <= 1'b0;
      rgb_q  <= 3'b000;
    end else begin
      addr_q <= addr_d;
      win1_q <= in_win & ~bus.iCLR;
      win2_q <= win1_q & ~bus.iCLR;
      rgb_q  <= (win2_q && !bus.iCLR && (state_q == ST_SHOW) && vis_q && bus.iROM_Q)
                ? FG_RGB : 3'b000;
    end
  end

  assign bus.oROM_ADDR  = addr_q;
  assign bus.oRGB       = rgb_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oBANNER_ID = id_q;

endmodule

// File: tb/tb_text_banner_ctrl.sv
// Purpose: scoreboard bench for text_banner_ctrl with a synchronous ROM model and directed vectors.
// Latency: expectations are queued with their due cycle and compared on the falling edge.
// Backpressure: none.
module tb_text_banner_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  text_banner_ctrl_if bus_if();

  text_banner_ctrl #(.SHOW_FRAMES(4), .BLINK_PERIOD(2)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model: 0 = all clear, 1 = all set, 2 = address bit 0
  int   rom_mode = 0;
  logic rom_q = 1'b0;
  always @(posedge clk)
    rom_q <= (rom_mode == 1) ? 1'b1 : (rom_mode == 2) ? bus_if.oROM_ADDR[0] : 1'b0;
  assign bus_if.iROM_Q = rom_q;

  typedef struct {
    int          due;
    logic [14:0] val;
    string       name;
  } exp_t;

  // kinds: 0 addr, 1 rgb, 2 busy, 3 banner id
  exp_t q[4][$];
  int checks = 0;
  int errors = 0;

  task automatic push_exp(input int kind, input int dly, input logic [14:0] v, input string nm);
    exp_t e;
    e.due  = cyc + dly;
    e.val  = v;
    e.name = nm;
    q[kind].push_back(e);
  endtask

  // Monitor: compares every expectation on the falling edge of its due cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] act;
    for (int k = 0; k < 4; k++) begin
      while (q[k].size() > 0 && q[k][0].due <= cyc) begin
        e = q[k].pop_front();
        case (k)
          0:       act = bus_if.oROM_ADDR;
          1:       act = {12'd0, bus_if.oRGB};
          2:       act = {14'd0, bus_if.oBUSY};
          default: act = {13'd0, bus_if.oBANNER_ID};
        endcase
        checks++;
        if (e.due < cyc) begin
          errors++;
          $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.due, cyc);
        end else if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.val, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] r);
    bus_if.iREQ = r;
    step();
    bus_if.iREQ = 4'd0;
  endtask

  // Frame-start pulse; request/clear driven alongside it are single-cycle too
  task automatic fs(input logic b, input logic [1:0] id, input string nm);
    bus_if.iFRAME_START = 1'b1;
    push_exp(2, 1, {14'd0, b}, {nm, "_busy"});
    push_exp(3, 1, {13'd0, id}, {nm, "_id"});
    step();
    bus_if.iFRAME_START = 1'b0;
    bus_if.iREQ         = 4'd0;
    bus_if.iCLR         = 1'b0;
    step();
  endtask

  task automatic pix(input int x, input int y, input logic [14:0] ea, input logic [2:0] er, input string nm);
    bus_if.iVGA_X = 10'(x);
    bus_if.iVGA_Y = 10'(y);
    push_exp(0, 1, ea, {nm, "_addr"});
    push_exp(1, 3, {12'd0, er}, {nm, "_rgb"});
    step();
  endtask

  // Park the scan outside the window and let the pixel pipeline empty
  task automatic pix_done();
    bus_if.iVGA_X = 10'd0;
    bus_if.iVGA_Y = 10'd0;
    repeat (3) step();
  endtask

  initial begin
    bus_if.iVGA_X       = 10'd0;
    bus_if.iVGA_Y       = 10'd0;
    bus_if.iFRAME_START = 1'b0;
    bus_if.iREQ         = 4'd0;
    bus_if.iCLR         = 1'b0;
    repeat (2) step();
    push_exp(0, 0, 15'd0, "rst_addr");
    push_exp(1, 0, 15'd0, "rst_rgb");
    push_exp(2, 0, 15'd0, "rst_busy");
    push_exp(3, 0, 15'd0, "rst_id");
    step();
    rst_n = 1'b1;
    step();

    // Banner 0: window corners, edges just outside, ROM data steering colour
    req(4'b0001);
    fs(1'b1, 2'd0, "b0_start");
    rom_mode = 1;
    pix(350, 300, 15'd0,    3'b001, "corner_tl");
    pix(470, 300, 15'd0,    3'b000, "x_past_right");
    pix(469, 347, 15'd5759, 3'b001, "corner_br");
    pix(349, 300, 15'd0,    3'b000, "x_before_left");
    pix(350, 348, 15'd0,    3'b000, "y_past_bottom");
    pix(350, 299, 15'd0,    3'b000, "y_before_top");
    pix_done();
    rom_mode = 2;
    pix(351, 300, 15'd1, 3'b001, "rom_bit_set");
    pix(352, 300, 15'd2, 3'b000, "rom_bit_clear");
    pix_done();
    rom_mode = 1;

    // Frames 1..3 then GAP: visible, hidden, hidden, blank; then IDLE
    for (int f = 1; f <= 4; f++) begin
      fs(1'b1, 2'd0, "blink_frame");
      pix(351, 301, 15'd121, (f == 1) ? 3'b001 : 3'b000, "blink_pix");
      pix_done();
    end
    fs(1'b0, 2'd0, "b0_idle");

    // Banner 2 address, then clear with a simultaneous request
    req(4'b0100);
    fs(1'b1, 2'd2, "b2_start");
    pix(351, 301, 15'd11641, 3'b001, "b2_pix");
    pix_done();
    bus_if.iCLR = 1'b1;
    bus_if.iREQ = 4'b0100;
    push_exp(2, 1, 15'd0, "clr_busy");
    pix(351, 301, 15'd11641, 3'b000, "clr_pix");
    bus_if.iCLR = 1'b0;
    bus_if.iREQ = 4'd0;
    pix(351, 301, 15'd11641, 3'b000, "after_clr_pix");
    pix_done();
    fs(1'b0, 2'd2, "clr_pend_empty");

    // Two requests at once: banner 1 full run, GAP, then banner 0
    req(4'b0011);
    fs(1'b1, 2'd1, "pair_b1");
    repeat (3) fs(1'b1, 2'd1, "pair_b1_run");
    fs(1'b1, 2'd1, "pair_gap1");
    fs(1'b1, 2'd0, "pair_b0");
    repeat (3) fs(1'b1, 2'd0, "pair_b0_run");
    fs(1'b1, 2'd0, "pair_gap0");
    fs(1'b0, 2'd0, "pair_idle");

    // Higher-priority request arriving while banner 0 shows
    req(4'b0001);
    fs(1'b1, 2'd0, "pre_b0");
    step();
    req(4'b1000);
`ifdef TEXT_BANNER_PREEMPT_EN
    fs(1'b1, 2'd3, "pre_b3");
`else
    repeat (3) fs(1'b1, 2'd0, "pre_b0_run");
    fs(1'b1, 2'd0, "pre_gap0");
    fs(1'b1, 2'd3, "pre_b3");
`endif
    repeat (3) fs(1'b1, 2'd3, "pre_b3_run");
    fs(1'b1, 2'd3, "pre_gap3");
    fs(1'b0, 2'd3, "pre_idle");

    // Request on the frame-start cycle is taken that frame; iCLR beats FS and iREQ
    bus_if.iREQ = 4'b0010;
    fs(1'b1, 2'd1, "same_cycle_req");
    bus_if.iCLR = 1'b1;
    bus_if.iREQ = 4'b1000;
    fs(1'b0, 2'd1, "clr_beats_fs");
    fs(1'b0, 2'd1, "clr_dropped_req");

    // Asynchronous reset mid-frame while drawing
    req(4'b0100);
    fs(1'b1, 2'd2, "ar_b2");
    bus_if.iVGA_X = 10'd350;
    bus_if.iVGA_Y = 10'd300;
    repeat (4) step();
    push_exp(1, 0, 15'd1, "ar_rgb_before");
    step();
    rst_n = 1'b0;
    push_exp(0, 0, 15'd0, "ar_addr");
    push_exp(1, 0, 15'd0, "ar_rgb");
    push_exp(2, 0, 15'd0, "ar_busy");
    push_exp(3, 0, 15'd0, "ar_id");
    repeat (2) step();
    rst_n = 1'b1;
    pix_done();
    fs(1'b0, 2'd0, "ar_idle");
    req(4'b0001);
    fs(1'b1, 2'd0, "ar_resume");

    repeat (6) step();
    for (int k = 0; k < 4; k++) begin
      while (q[k].size() > 0) begin
        exp_t e;
        e = q[k].pop_front();
        checks++;
        errors++;
        $display("FAIL %s: never compared, due cycle %0d", e.name, e.due);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_banner_ctrl.md
# text_banner_ctrl

Sequencer for the on-screen text banners (SCORE, LEVEL, PAUSE, GAME OVER) that share one synchronous 1-bit banner ROM. Arbitrates banner requests from game logic, holds the selected banner for a programmed number of frames with optional blinking, and generates the ROM address and the overlay colour in lock-step with the VGA scan position. Sits between the game FSM and the VGA RGB mux, replacing per-banner display blocks that each own a ROM.

## Interface
- BANNER_X, 350, left column of banner window
- BANNER_Y, 300, top row of banner window
- BANNER_W, 120, banner width in pixels
- BANNER_H, 48, banner height in pixels
- SHOW_FRAMES, 180, frames a banner stays up (1..255)
- BLINK_PERIOD, 16, frames per blink half-period; 0 = no blink
- FG_RGB, 3'b001, colour for set ROM pixels

- iVGA_CLK  in  1  pixel clock, all logic on rising edge
- iRST_n  in  1  reset, asynchronous, active-low
- iVGA_X  in  10  current scan column
- iVGA_Y  in  10  current scan row
- iFRAME_START  in  1  one-cycle pulse at start of each frame
- iREQ  in  4  banner request pulses; bit n = banner n, bit 3 highest priority
- iCLR  in  1  cancel current and all pending banners
- iROM_Q  in  1  ROM pixel, valid one cycle after oROM_ADDR
- oROM_ADDR  out  15  ROM address
- oRGB  out  3  overlay colour, 3'b000 = transparent
- oBUSY  out  1  a banner is active (SHOW or GAP)
- oBANNER_ID  out  2  banner currently shown

## Operation
- ROM layout: banner n at base n*BANNER_W*BANNER_H, row-major; address = base + (Y-BANNER_Y)*BANNER_W + (X-BANNER_X), computed in 15 bits.
- Pending register pend[3:0]: set by iREQ bits, cleared when that banner is selected. Selection uses pend|iREQ, so a request on a frame-start cycle is seen that frame.
- States: IDLE, SHOW, GAP.
- IDLE: on iFRAME_START with any pending -> SHOW, select highest pending bit, frame_cnt=0, blink phase visible.
- SHOW: on each iFRAME_START frame_cnt++; at frame_cnt==SHOW_FRAMES-1 -> GAP. Re-request of the shown ID restarts frame_cnt at next iFRAME_START.
- GAP: exactly one blank frame; at next iFRAME_START -> SHOW with next pending, else IDLE.
- All state/ID/counter changes only on iFRAME_START cycles (no mid-frame tearing), except iCLR.
- iCLR: same-cycle clear of pend, state -> IDLE, in-window pipeline bits cleared; iCLR wins over simultaneous iREQ/iFRAME_START.
- Blink: if BLINK_PERIOD>0, phase toggles every BLINK_PERIOD frames of SHOW; hidden phase forces oRGB=0 but addresses still generated.
- oRGB = FG_RGB when delayed in-window & SHOW & visible & iROM_Q, else 3'b000. Outside window oROM_ADDR = 0.
- oBUSY = (state != IDLE); oBANNER_ID holds last selected ID in IDLE/GAP.

## Timing
- Reset values: oROM_ADDR 0, oRGB 0, oBUSY 0, oBANNER_ID 0, pend 0, state IDLE, counters 0.
- Cycle 0: iVGA_X/Y sampled; cycle 1: oROM_ADDR and in-window flag registered; cycle 2: iROM_Q valid; edge ending cycle 2: oRGB registered. Total X/Y -> oRGB latency 3 clocks; window gating delayed identically so edges align with pixel data.
- Request pulse of one cycle is never lost; repeated requests of a pending ID collapse to one.
- Window bounds inclusive: X in [BANNER_X, BANNER_X+BANNER_W-1], Y in [BANNER_Y, BANNER_Y+BANNER_H-1].
- Async reset mid-frame: outputs 0 immediately; resumes at first iFRAME_START after release.

## Configuration
- TEXT_BANNER_PREEMPT_EN defined: in SHOW, on iFRAME_START a pending ID higher than the shown ID switches directly to it (frame_cnt=0, no GAP); preempted banner is dropped, not re-queued.
- Undefined: a shown banner always runs to SHOW_FRAMES, then GAP, then highest pending.

## Test plan
- Reset, iREQ=4'b0001, one frame start -> oBUSY=1, oBANNER_ID=0; pixel X=350,Y=300 yields oROM_ADDR=0 one clock later, oRGB=FG_RGB 3 clocks after X/Y when iROM_Q=1; X=470 -> oRGB=0.
- Banner 2 active, X=351,Y=301 -> oROM_ADDR=2*5760+121=11641.
- SHOW_FRAMES=4, BLINK_PERIOD=2, iROM_Q=1 -> visible frames 0,1, hidden 2,3, one GAP frame, then IDLE, oBUSY=0.
- iREQ=4'b0011 same cycle -> banner 1 shown full duration, GAP, then banner 0.
- Banner 0 showing, iREQ bit 3 mid-frame: with TEXT_BANNER_PREEMPT_EN -> oBANNER_ID=3 at next frame start; without -> 3 after banner 0 and GAP.
- iCLR with iREQ=4'b0100 same cycle during SHOW -> next cycle oBUSY=0, pend=0, oRGB=0 on following pixels.
